// File: rtl/udma_external_per_cfg_seq.sv
// udma_external_per_cfg_seq: programs one RX/TX uDMA channel transfer from a descriptor
// over the cfg bus, then polls CFG until the channel goes idle.
module udma_external_per_cfg_seq #(
  parameter int L2_AWIDTH_NOAL = 12,
  parameter int TRANS_SIZE     = 16,
  parameter int POLL_GAP       = 4,
  parameter int MAX_POLLS      = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      desc_valid_i,
  output logic                      desc_ready_o,
  input  logic                      desc_dir_i,
  input  logic [L2_AWIDTH_NOAL-1:0] desc_addr_i,
  input  logic [TRANS_SIZE-1:0]     desc_size_i,
  input  logic [1:0]                desc_datasize_i,
  input  logic                      desc_continuous_i,
  input  logic                      abort_i,
  output logic                      cfg_valid_o,
  output logic                      cfg_rwn_o,
  output logic [4:0]                cfg_addr_o,
  output logic [31:0]               cfg_data_o,
  input  logic [31:0]               cfg_data_i,
  input  logic                      cfg_ready_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [1:0]                done_status_o
);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);
  typedef enum logic [2:0] {IDLE, WR_SADDR, WR_SIZE, WR_CFG, WAIT, POLL, ABORT} state_t;
  state_t state;
  logic dir, cont, abort_pend, timeout, abort_now, unused_data;
  logic [1:0] dsize;
  logic [TRANS_SIZE-1:0] size;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] poll_cnt;
  logic [4:0] cfg_reg;
  assign cfg_reg     = {2'b00, dir, 2'b10};
  assign abort_now   = abort_i | abort_pend;
  assign unused_data = ^{cfg_data_i[31:6], cfg_data_i[3:0]};
  // In the bus states cfg_valid_o is always high, so cfg_ready_i alone marks the accept cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      desc_ready_o  <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      done_status_o <= 2'b00;
      cfg_valid_o   <= 1'b0;
      cfg_rwn_o     <= 1'b0;
      cfg_addr_o    <= '0;
      cfg_data_o    <= '0;
      dir           <= 1'b0;
      cont          <= 1'b0;
      dsize         <= '0;
      size          <= '0;
      gap_cnt       <= '0;
      poll_cnt      <= '0;
      abort_pend    <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i && state != IDLE && state != ABORT) abort_pend <= 1'b1;
      case (state)
        IDLE: begin
          desc_ready_o <= 1'b1;
          if (desc_valid_i && desc_ready_o) begin
            dir        <= desc_dir_i;
            cont       <= desc_continuous_i;
            dsize      <= desc_datasize_i;
            size       <= desc_size_i;
            poll_cnt   <= '0;
            abort_pend <= 1'b0;
            timeout    <= 1'b0;
            if (desc_size_i == '0) begin
              done_o        <= 1'b1;
              done_status_o <= 2'b00;
            end else begin
              state        <= WR_SADDR;
              desc_ready_o <= 1'b0;
              busy_o       <= 1'b1;
              cfg_valid_o  <= 1'b1;
              cfg_rwn_o    <= 1'b0;
              cfg_addr_o   <= {2'b00, desc_dir_i, 2'b00};
              cfg_data_o   <= 32'(desc_addr_i);
            end
          end
        end
        WAIT: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (abort_now) begin
            state <= ABORT; cfg_valid_o <= 1'b1; cfg_rwn_o <= 1'b0; cfg_addr_o <= cfg_reg; cfg_data_o <= 32'h20;
          end else if (gap_cnt == GW'(POLL_GAP - 1)) begin
            state <= POLL; cfg_valid_o <= 1'b1; cfg_rwn_o <= 1'b1; cfg_addr_o <= cfg_reg; cfg_data_o <= '0;
          end
        end
        ABORT: if (cfg_ready_i) begin
          state         <= IDLE;
          cfg_valid_o   <= 1'b0;
          busy_o        <= 1'b0;
          desc_ready_o  <= 1'b1;
          done_o        <= 1'b1;
          done_status_o <= timeout ? 2'b10 : 2'b01;
        end
        default: if (cfg_ready_i) begin
          if (abort_now) begin
            state <= ABORT; cfg_valid_o <= 1'b1; cfg_rwn_o <= 1'b0; cfg_addr_o <= cfg_reg; cfg_data_o <= 32'h20;
          end else if (state == WR_SADDR) begin
            state      <= WR_SIZE;
            cfg_addr_o <= {2'b00, dir, 2'b01};
            cfg_data_o <= 32'(size);
          end else if (state == WR_SIZE) begin
            state      <= WR_CFG;
            cfg_addr_o <= cfg_reg;
            cfg_data_o <= {26'h0, 3'b010, dsize, cont};
          end else if ((state == WR_CFG && cont) || (state == POLL && cfg_data_i[5:4] == 2'b00)) begin
            state         <= IDLE;
            cfg_valid_o   <= 1'b0;
            busy_o        <= 1'b0;
            desc_ready_o  <= 1'b1;
            done_o        <= 1'b1;
            done_status_o <= 2'b00;
          end else if (state == WR_CFG || poll_cnt != PW'(MAX_POLLS - 1)) begin
            state       <= WAIT;
            cfg_valid_o <= 1'b0;
            gap_cnt     <= '0;
            poll_cnt    <= poll_cnt + PW'(state == POLL);
          end else begin
            timeout <= 1'b1;
            state <= ABORT; cfg_valid_o <= 1'b1; cfg_rwn_o <= 1'b0; cfg_addr_o <= cfg_reg; cfg_data_o <= 32'h20;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_udma_external_per_cfg_seq.sv
// tb_udma_external_per_cfg_seq: builds a per-descriptor expected timeline from the transfer
// rules and checks every DUT output against it each cycle.
module tb_udma_external_per_cfg_seq;
  localparam int AW = 12, TS = 16, GAP = 4, MP = 3, N = 128;
  logic clk = 1'b0, rst_i;
  logic desc_valid_i, desc_ready_o, desc_dir_i, desc_continuous_i, abort_i;
  logic [AW-1:0] desc_addr_i;
  logic [TS-1:0] desc_size_i;
  logic [1:0] desc_datasize_i, done_status_o;
  logic cfg_valid_o, cfg_rwn_o, cfg_ready_i, busy_o, done_o;
  logic [4:0] cfg_addr_o;
  logic [31:0] cfg_data_o, cfg_data_i;
  always #5 clk = ~clk;

  udma_external_per_cfg_seq #(.L2_AWIDTH_NOAL(AW), .TRANS_SIZE(TS), .POLL_GAP(GAP), .MAX_POLLS(MP)) dut (
    .clk_i(clk), .rst_i(rst_i), .desc_valid_i(desc_valid_i), .desc_ready_o(desc_ready_o),
    .desc_dir_i(desc_dir_i), .desc_addr_i(desc_addr_i), .desc_size_i(desc_size_i),
    .desc_datasize_i(desc_datasize_i), .desc_continuous_i(desc_continuous_i), .abort_i(abort_i),
    .cfg_valid_o(cfg_valid_o), .cfg_rwn_o(cfg_rwn_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
    .cfg_data_i(cfg_data_i), .cfg_ready_i(cfg_ready_i), .busy_o(busy_o), .done_o(done_o),
    .done_status_o(done_status_o)
  );

  int checks = 0, fails = 0;
  logic e_valid[N], e_rwn[N], e_done[N], e_busy[N], e_dready[N], s_ready[N], s_abort[N];
  logic [4:0] e_addr[N];
  logic [31:0] e_data[N], s_data[N];
  logic [1:0] e_status[N];
  logic d_dir, d_cont;
  logic [AW-1:0] d_addr;
  logic [TS-1:0] d_size;
  logic [1:0] d_ds, exp_status, carry_status;
  logic carry_done, chk_en;
  logic poll_busy[MP];
  int force_item, force_stall, max_stall, abort_at, n_item, done_at, off;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h (offset %0d, t=%0t)", name, got, want, off, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("busy", busy_o, e_busy[off]);
    chk("desc_ready", desc_ready_o, e_dready[off]);
    chk("done", done_o, e_done[off]);
    chk("cfg_valid", cfg_valid_o, e_valid[off]);
    if (e_valid[off]) begin
      chk("cfg_rwn", cfg_rwn_o, e_rwn[off]);
      chk("cfg_addr", cfg_addr_o, e_addr[off]);
      if (!e_rwn[off]) chk("cfg_data", cfg_data_o, e_data[off]);
    end
    if (e_done[off]) chk("done_status", done_status_o, e_status[off]);
  end

  task automatic set_desc(input logic dir, input logic [AW-1:0] a, input logic [TS-1:0] s, input logic [1:0] ds, input logic c);
    d_dir = dir; d_addr = a; d_size = s; d_ds = ds; d_cont = c;
  endtask

  // One bus transaction starting at cycle t, held until the cycle the responder accepts it.
  task automatic place(input int t, input logic rwn, input logic [4:0] a, input logic [31:0] dat, output int tend);
    int st;
    st = (n_item == force_item) ? force_stall : int'($urandom_range(0, max_stall));
    n_item++;
    for (int c = t; c <= t + st; c++) begin
      e_valid[c] = 1'b1; e_rwn[c] = rwn; e_addr[c] = a; e_data[c] = dat; s_ready[c] = (c == t + st);
    end
    tend = t + st;
  endtask

  task automatic build();
    int t, te;
    bit ab, to;
    logic [4:0] base;
    logic [1:0] bb;
    for (int c = 0; c < N - 1; c++) begin
      e_valid[c] = 0; e_rwn[c] = 0; e_addr[c] = 0; e_data[c] = 0; e_done[c] = 0; e_status[c] = 0;
      e_busy[c] = 1; e_dready[c] = 0; s_ready[c] = 1'($urandom_range(0, 1)); s_abort[c] = (c == abort_at); s_data[c] = $urandom;
    end
    e_busy[0] = 0; e_dready[0] = 1; e_done[0] = carry_done; e_status[0] = carry_status;
    base = {2'b00, d_dir, 2'b00}; n_item = 0; ab = 0; to = 0; t = 1;
    if (d_size == 0) done_at = 1;
    else begin
      place(t, 0, base, 32'(d_addr), te); ab = abort_at >= 1 && abort_at <= te; t = te + 1;
      if (!ab) begin place(t, 0, base | 5'd1, 32'(d_size), te); ab = abort_at >= 1 && abort_at <= te; t = te + 1; end
      if (!ab) begin place(t, 0, base | 5'd2, {26'h0, 3'b010, d_ds, d_cont}, te); ab = abort_at >= 1 && abort_at <= te; t = te + 1; end
      if (!ab && !d_cont) begin
        for (int p = 0; p < MP; p++) begin
          if (abort_at >= t && abort_at < t + GAP) begin ab = 1; t = abort_at + 1; break; end
          t += GAP;
          place(t, 1, base | 5'd2, 32'h0, te);
          bb = poll_busy[p] ? 2'($urandom_range(1, 3)) : 2'b00;
          s_data[te] = ($urandom & ~32'h30) | {26'h0, bb, 4'h0};
          t = te + 1;
          if (abort_at >= 1 && abort_at <= te) begin ab = 1; break; end
          if (!poll_busy[p]) break;
          if (p == MP - 1) to = 1;
        end
      end
      if (ab || to) begin place(t, 0, base | 5'd2, 32'h20, te); t = te + 1; end
      done_at = t;
    end
    exp_status = to ? 2'b10 : ab ? 2'b01 : 2'b00;
  endtask

  task automatic run(input int lim);
    desc_dir_i = d_dir; desc_addr_i = d_addr; desc_size_i = d_size; desc_datasize_i = d_ds; desc_continuous_i = d_cont;
    for (int k = 0; k < done_at && k < lim; k++) begin
      desc_valid_i = (k == 0) || ($urandom_range(0, 3) == 0);
      abort_i = s_abort[k]; cfg_ready_i = s_ready[k]; cfg_data_i = s_data[k]; off = k; chk_en = 1;
      @(posedge clk); #1;
    end
    chk_en = 0; desc_valid_i = 0; abort_i = 0;
    carry_done = lim >= done_at; carry_status = exp_status;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      e_valid[N-1] = 0; e_busy[N-1] = 0; e_dready[N-1] = 1; e_done[N-1] = carry_done; e_status[N-1] = carry_status;
      desc_valid_i = 0; abort_i = 1'($urandom_range(0, 1)); cfg_ready_i = 1'($urandom_range(0, 1));
      off = N - 1; chk_en = 1; carry_done = 0;
      @(posedge clk); #1;
    end
    chk_en = 0; abort_i = 0;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_valid"}, cfg_valid_o, 0); chk({name, "_rwn"}, cfg_rwn_o, 0);
    chk({name, "_addr"}, cfg_addr_o, 0); chk({name, "_data"}, cfg_data_o, 0);
    chk({name, "_ready"}, desc_ready_o, 0); chk({name, "_busy"}, busy_o, 0);
    chk({name, "_done"}, done_o, 0); chk({name, "_status"}, done_status_o, 0);
  endtask

  initial begin
    rst_i = 1; desc_valid_i = 0; desc_dir_i = 0; desc_addr_i = 0; desc_size_i = 0; desc_datasize_i = 0;
    desc_continuous_i = 0; abort_i = 0; cfg_data_i = 0; cfg_ready_i = 0; chk_en = 0; off = 0;
    carry_done = 0; carry_status = 0; max_stall = 0; force_item = -1; force_stall = 0; abort_at = -1;
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    rst_i = 0;
    @(negedge clk) chk("ready_first_cycle", desc_ready_o, 0);
    @(posedge clk); #1;

    set_desc(1, 12'h123, 16'h40, 2, 0); poll_busy = '{1, 1, 0}; build();
    chk("m_tx_saddr", {e_addr[1], e_data[1]}, {5'd4, 32'h123});
    chk("m_tx_size", {e_addr[2], e_data[2]}, {5'd5, 32'h40});
    chk("m_tx_cfg", {e_addr[3], e_data[3]}, {5'd6, 32'h14});
    chk("m_tx_polls", {e_rwn[8], e_rwn[13], e_rwn[18], e_valid[9]}, 4'b1110);
    chk("m_tx_done_at", done_at, 19);
    run(N);

    set_desc(0, 12'h055, 16'd8, 0, 1); build();
    chk("m_rx_cont_cfg", {e_addr[3], e_data[3]}, {5'd2, 32'h11});
    chk("m_rx_cont_done_at", done_at, 4);
    run(N);

    set_desc(0, 12'h007, 16'h99, 1, 0); poll_busy = '{0, 1, 1}; force_item = 1; force_stall = 5; build();
    chk("m_stall_hold", {e_valid[5], e_addr[5], e_data[5], s_ready[6], s_ready[7]}, {1'b1, 5'd1, 32'h99, 2'b01});
    chk("m_stall_done_at", done_at, 14);
    run(N); force_item = -1;

    set_desc(0, 12'h010, 16'h20, 3, 0); poll_busy = '{1, 1, 1}; abort_at = 6; build();
    chk("m_abort_wait", {e_addr[7], e_data[7], exp_status}, {5'd2, 32'h20, 2'b01});
    chk("m_abort_wait_done_at", done_at, 8);
    run(N);

    set_desc(1, 12'h001, 16'h4, 0, 0); abort_at = -1; build();
    chk("m_timeout", {e_addr[19], e_data[19], exp_status}, {5'd6, 32'h20, 2'b10});
    chk("m_timeout_done_at", done_at, 20);
    run(N);

    set_desc(0, 12'hfff, 16'h0, 1, 0); build();
    chk("m_size0_done_at", done_at, 1);
    run(N); idle(2);

    set_desc(1, 12'h003, 16'h3, 1, 0); poll_busy = '{0, 0, 0}; abort_at = 8; build();
    chk("m_abort_last_poll", {done_at, 30'(0), exp_status}, {32'd10, 30'(0), 2'b01});
    run(N);

    max_stall = 2;
    for (int i = 0; i < 60; i++) begin
      set_desc(1'($urandom_range(0, 1)), AW'($urandom), ($urandom_range(0, 7) == 0) ? '0 : TS'($urandom_range(1, 65535)),
               2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0);
      for (int p = 0; p < MP; p++) poll_busy[p] = 1'($urandom_range(0, 1));
      abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : -1;
      build(); run(N);
      idle($urandom_range(0, 2));
    end
    idle(1);

    set_desc(0, 12'h001, 16'h1, 0, 0); poll_busy = '{1, 1, 1}; max_stall = 0; abort_at = -1; build();
    run(9);
    rst_i = 1; cfg_ready_i = 0;
    @(posedge clk); #1 rst_i = 0;
    @(negedge clk) chk_reset_vals("midpoll_reset");
    @(posedge clk); #1;
    @(negedge clk) begin
      chk("post_reset_ready", desc_ready_o, 1); chk("post_reset_valid", cfg_valid_o, 0);
      chk("post_reset_done", done_o, 0); chk("post_reset_busy", busy_o, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/udma_external_per_cfg_seq.md
# udma_external_per_cfg_seq

Descriptor-driven sequencer for the external-peripheral uDMA channel configuration port. It accepts one RX or TX transfer descriptor at a time and programs the channel through the 5-bit-address cfg bus: start address, size, then CFG with enable. For non-continuous transfers it polls the CFG register until the channel is idle, then reports completion. It sits between a control master (FSM or core-side queue) and the channel register file, replacing software programming of the channel.

## Interface
- L2_AWIDTH_NOAL, 12: channel start-address width.
- TRANS_SIZE, 16: transfer-size width.
- POLL_GAP, 4: idle cycles between CFG status polls, at least 1.
- MAX_POLLS, 1024: polls before timeout, at least 1.

- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- desc_valid_i  in  1  descriptor offered.
- desc_ready_o  out  1  sequencer can accept a descriptor.
- desc_dir_i  in  1  0 = RX, 1 = TX.
- desc_addr_i  in  L2_AWIDTH_NOAL  L2 start address.
- desc_size_i  in  TRANS_SIZE  size in bytes.
- desc_datasize_i  in  2  CFG datasize field.
- desc_continuous_i  in  1  continuous mode.
- abort_i  in  1  abort the in-flight descriptor.
- cfg_valid_o  out  1  cfg transaction request.
- cfg_rwn_o  out  1  1 = read, 0 = write.
- cfg_addr_o  out  5  register word address.
- cfg_data_o  out  32  write data.
- cfg_data_i  in  32  read data, valid in the accept cycle.
- cfg_ready_i  in  1  transaction accepted.
- busy_o  out  1  a descriptor is in flight.
- done_o  out  1  one-cycle completion pulse.
- done_status_o  out  2  valid with done_o: 00 ok, 01 aborted, 10 timeout.

## Operation
- Register addresses: RX_SADDR 0, RX_SIZE 1, RX_CFG 2, TX_SADDR 4, TX_SIZE 5, TX_CFG 6. TX addresses are the RX addresses plus 4.
- CFG write fields:
  - bit5: clr.
  - bit4: en.
  - bits 2:1: datasize.
  - bit0: continuous.
- CFG read fields: bit5 pending, bit4 en.
- States: IDLE, WR_SADDR, WR_SIZE, WR_CFG, WAIT, POLL, ABORT.
- IDLE:
  - desc_ready_o = 1.
  - On desc_valid_i, latch all descriptor fields.
  - If size = 0, emit done_o with status 00 immediately from IDLE, with no bus traffic.
  - Otherwise go to WR_SADDR.
- WR_SADDR: write the zero-extended address.
- WR_SIZE: write the zero-extended size.
- WR_CFG: write {26'h0, 1'b0, 1'b1, 1'b0, datasize, continuous}.
- After WR_CFG:
  - Continuous: go to IDLE and pulse done_o with status 00.
  - Otherwise: go to WAIT.
- WAIT: count POLL_GAP cycles, then go to POLL.
- POLL:
  - Issue a read of the CFG address.
  - On accept, if cfg_data_i[5:4] == 2'b00, go to IDLE with done_o and status 00.
  - Otherwise increment the poll counter. If the counter reaches MAX_POLLS, set the timeout flag and go to ABORT; else go to WAIT.
- ABORT:
  - Write CFG = 32'h20 (clr only) to the latched direction.
  - Then go to IDLE with done_o. Status is 10 if the timeout flag is set, else 01.
- abort_i:
  - Sampled every non-IDLE cycle; a sample sets a sticky abort-pending flag.
  - In WAIT: go to ABORT next cycle.
  - In WR_* / POLL: the outstanding transaction completes first (no valid withdrawal), then go to ABORT. The poll result is ignored.
  - Ignored in IDLE and in ABORT.
- busy_o = (state != IDLE).
- Poll counter and flags clear on every descriptor accept.

## Timing
- All outputs are registered. Reset values:
  - cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o: 0.
  - desc_ready_o: 0 during reset, 1 the cycle after reset deasserts.
  - busy_o, done_o, done_status_o: 0.
- Handshake:
  - A transaction completes in a cycle with cfg_valid_o & cfg_ready_i.
  - cfg_valid_o, cfg_addr_o, cfg_data_o and cfg_rwn_o hold stable until accepted.
  - The next transaction may be driven in the following cycle.
- With cfg_ready_i held at 1 and accept at cycle T:
  - SADDR write at T+1, SIZE at T+2, CFG at T+3.
  - WAIT at T+4..T+3+POLL_GAP, first poll at T+4+POLL_GAP.
  - done_o in the cycle after the accepted idle poll, coincident with desc_ready_o = 1.
- A new descriptor may be accepted in the same cycle done_o is high.
- Reset mid-transfer: next cycle is IDLE with cfg_valid_o = 0. No clr write is issued. No done_o.
- abort_i in the same cycle as the final idle poll's acceptance: abort wins, giving the ABORT write and status 01.

## Test plan
- TX descriptor (addr 0x123, size 0x40, datasize 2, non-continuous), cfg_ready_i = 1, status 0x10 for two polls then 0x00:
  - Writes addr4 = 0x123, addr5 = 0x40, addr6 = 0x14.
  - Three reads of addr6, each POLL_GAP+1 cycles apart.
  - done_o with status 00.
- RX continuous (size 8, datasize 0): writes addr0, addr1, then addr2 = 0x11; done_o status 00 the next cycle; zero reads.
- cfg_ready_i low for 5 cycles during the SIZE write: valid/addr/data stay stable (addr1, size) throughout; sequence resumes unchanged.
- abort_i pulsed in WAIT during RX: next transaction writes addr2 = 0x20; done_o with status 01.
- Status stuck at 0x10 with MAX_POLLS = 3: exactly 3 reads, then write addr6 = 0x20; done_o with status 10.
- Size-0 descriptor: no cfg_valid_o; done_o with status 00 one cycle after accept. Separately, rst_i asserted mid-poll: all outputs go to their reset values next cycle.
